// File: rtl/alu_instruction_assembler.sv
// Assembles decoded ALU control fields into 16-bit instruction words and streams
// them into instruction memory through a single-entry write register.
module alu_instruction_assembler #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [3:0]  INC_OPCODE = 4'hE,
  parameter logic [3:0]  NOP_OPCODE = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [3:0]        in_alu_op,
  input  logic [3:0]        in_a_select,
  input  logic [3:0]        in_b_select,
  input  logic [3:0]        in_out_select,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              error,
  output logic [1:0]        error_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CAPACITY = CNT_ONE << ADDR_W;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;

  logic        accept, commit;
  logic        bad_kind, imm_bad, reg_bad;
  logic [1:0]  req_code;
  logic [15:0] enc_word;

  assign in_ready   = (state_q == S_RUN) & ~start & (~we_q | mem_ready);
  assign busy       = (state_q == S_RUN) | we_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign count      = count_q;
  assign error      = error_q;
  assign error_code = code_q;

  assign accept = in_valid & in_ready;
  assign commit = we_q & mem_ready;

  always_comb begin
    bad_kind = (in_kind == 2'd3) ||
               ((in_kind == 2'd1) && ((in_alu_op == INC_OPCODE) || (in_alu_op == NOP_OPCODE)));
    // Immediate fits in 8 signed bits only when bits [15:7] are a pure sign extension.
    imm_bad  = (in_kind == 2'd2) && !((&in_imm[15:7]) || !(|in_imm[15:7]));
    reg_bad  = (in_kind == 2'd2) && (in_a_select != in_out_select);
    if (bad_kind)     req_code = 2'd1;
    else if (imm_bad) req_code = 2'd2;
    else if (reg_bad) req_code = 2'd3;
    else              req_code = 2'd0;

    case (in_kind)
      2'd1:    enc_word = {in_alu_op, in_a_select, in_b_select, in_out_select};
      2'd2:    enc_word = {INC_OPCODE, in_imm[7:0], in_out_select};
      default: enc_word = {NOP_OPCODE, 12'h000};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    issued_d = issued_q;
    error_d  = error_q;
    code_d   = code_q;
    if (start) begin
      state_d  = S_RUN;
      we_d     = 1'b0;
      addr_d   = base_addr;
      count_d  = '0;
      issued_d = '0;
      error_d  = 1'b0;
      code_d   = '0;
    end else begin
      // Committing first lets an accept in the same cycle target the following address.
      if (commit) begin
        addr_d = addr_q + ADDR_ONE;
        we_d   = 1'b0;
        if (count_q != CAPACITY) count_d = count_q + CNT_ONE;
      end
      if (accept) begin
        if (req_code != 2'd0) begin
          error_d = 1'b1;
          code_d  = req_code;
          state_d = S_ERR;
        end else begin
          we_d     = 1'b1;
          wdata_d  = enc_word;
          issued_d = issued_q + CNT_ONE;
          if (issued_q + CNT_ONE == CAPACITY) state_d = S_FULL;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      count_q  <= '0;
      issued_q <= '0;
      error_q  <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end

endmodule
